irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt request controller directly upstream of RV32core; drives the core's `interrupter` input.
- Synchronises asynchronous external interrupt sources and detects their rising edges.
- Latches pending requests, applies a software mask and selects the highest-priority request.
- Presents one request at a time to the core with an ack handshake and a post-ack holdoff, so the core never sees a merged or stale request.

Parameters:
- N_SRC, 4, number of external interrupt sources (1..16).
- SYNC_STAGES, 2, synchroniser flop depth per source (>=2).
- HOLDOFF_CYC, 2, cycles `interrupter` is forced low after an ack (>=1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset; all state clears while rst=0.
- src_in  input  N_SRC  asynchronous external interrupt lines, active-high.
- mask_we  input  1  write strobe for the mask register.
- mask_wdata  input  N_SRC  new mask value; bit=1 enables that source.
- mask  output  N_SRC  current mask register.
- interrupter  output  1  level request to the core.
- irq_id  output  4  index of the presented source; valid while interrupter=1.
- irq_ack  input  1  one-cycle pulse from the core when it takes the trap.
- pending  output  N_SRC  raw pending bits, masked and unmasked.

Behaviour:
- Reset (rst=0, asynchronous) clears:
  - synchroniser flops and edge-detect history;
  - pending, mask, irq_id and interrupter;
  - FSM to IDLE and the holdoff counter to 0.
- Synchroniser: each src_in bit passes through SYNC_STAGES flops. An edge-detect flop holds the previous synchronised value.
- Rising edge: sync=1 and prev=0 sets pending[i] in the following cycle. A src_in rise therefore reaches pending after SYNC_STAGES+1 clocks. Level-high without an edge sets nothing.
- Mask:
  - mask_we=1 loads mask_wdata on the clock edge.
  - Masked sources still latch pending.
  - Only pending & mask is eligible for a request.
- Priority: the lowest eligible index wins (fixed priority).
- FSM states:
  - IDLE:
    - interrupter=0.
    - If any eligible bit exists, latch the winning index into irq_id and go to REQ. interrupter rises in the next cycle, so an eligible bit reaches interrupter in 1 clock.
  - REQ:
    - interrupter=1; irq_id is frozen.
    - Pending/mask changes do not alter irq_id.
    - On irq_ack=1: clear pending[irq_id], load the holdoff counter with HOLDOFF_CYC and go to HOLD.
    - If the mask bit for irq_id is cleared while in REQ, the request is still held until ack. No retraction.
  - HOLD:
    - interrupter=0.
    - The counter decrements each cycle; at 0, go to IDLE.
    - Re-arbitration happens in IDLE, so the minimum gap between requests is HOLDOFF_CYC+1 low cycles.
- irq_ack outside REQ: ignored, no state change.
- Simultaneous set and clear of the same pending bit (a new edge on the acked source in the ack cycle): set wins, and the bit remains pending.
- Edges on a source that is already pending merge into a single pending bit.
- Reset asserted mid-REQ or mid-HOLD: interrupter drops immediately (asynchronous). After rst returns to 1, the FSM restarts in IDLE with nothing pending.
- irq_id is zero-extended to 4 bits.

Test Plan:
1. Single source:
   - Stimulus: reset, write mask=4'b1111, pulse src_in[2] high for 2 clocks.
   - Required response: pending[2]=1 3 clocks after the rise; interrupter=1 with irq_id=2 one clock later.
   - Then ack for 1 clock: pending=0, interrupter=0 for exactly 3 cycles, FSM back in IDLE.
2. Priority:
   - Stimulus: src_in[3] and src_in[1] rise in the same cycle.
   - Required response: irq_id=1 first. After the ack and holdoff, interrupter re-asserts with irq_id=3. After the second ack, pending=0.
3. Mask:
   - Stimulus: mask=4'b0001, edge on src_in[2].
   - Required response: pending=4'b0100 and interrupter stays 0.
   - Then write mask=4'b0100: interrupter=1 with irq_id=2 one clock after the write.
4. Ack/edge collision:
   - Stimulus: with irq_id=0 presented, a new src_in[0] edge is timed so pending[0] would set in the ack cycle.
   - Required response: pending[0] stays 1, and a second request with irq_id=0 follows after holdoff.
5. Spurious ack and reset:
   - Stimulus: irq_ack pulsed in IDLE.
   - Required response: no change.
   - Stimulus: rst=0 asserted mid-REQ.
   - Required response: interrupter=0 and pending=0 within the same cycle (before the next clock edge); mask=0 after release.
6. Level-high source:
   - Stimulus: hold src_in[1]=1 for 20 cycles.
   - Required response: exactly one pending set and one request; no retrigger after the ack while the line stays high.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt request controller: synchronises external lines, latches rising edges,
// masks and prioritises them, and presents one request at a time to the core.
module irq_ctrl #(
    parameter int N_SRC       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_in,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    output logic [N_SRC-1:0] mask,
    output logic             interrupter,
    output logic [3:0]       irq_id,
    input  logic             irq_ack,
    output logic [N_SRC-1:0] pending
);

    localparam int CW = $clog2(HOLDOFF_CYC + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    logic [N_SRC-1:0] sync_r [SYNC_STAGES];
    logic [N_SRC-1:0] prev_r;
    logic [N_SRC-1:0] sync_s;
    logic [N_SRC-1:0] rise_s;
    logic [N_SRC-1:0] elig_s;
    logic [N_SRC-1:0] clr_s;
    logic [N_SRC-1:0] pending_s;
    state_t           state_r;
    state_t           state_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_s;
    logic [3:0]       irq_id_s;
    logic             int_s;

    // Fixed priority: lowest set index wins, zero-extended to 4 bits.
    function automatic logic [3:0] prio_enc(input logic [N_SRC-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [N_SRC-1:0] onehot(input logic [3:0] idx);
        logic [N_SRC-1:0] one;
        one = {{(N_SRC-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    assign sync_s = sync_r[SYNC_STAGES-1];
    assign rise_s = sync_s & ~prev_r;
    assign elig_s = pending & mask;

    // Synchroniser chain and edge-detect history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
            prev_r <= '0;
        end else begin
            sync_r[0] <= src_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            prev_r <= sync_s;
        end
    end

    // Next-state, id capture, holdoff count and pending-clear selection.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        irq_id_s = irq_id;
        clr_s    = '0;
        int_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (|elig_s) begin
                    state_s  = REQ;
                    irq_id_s = prio_enc(elig_s);
                    int_s    = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                // Held until acked even if its mask bit is cleared meanwhile.
                if (irq_ack) begin
                    clr_s   = onehot(irq_id);
                    cnt_s   = CW'(HOLDOFF_CYC);
                    state_s = HOLD;
                    int_s   = 1'b0;
                end else begin
                    state_s = REQ;
                    int_s   = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_r <= CW'(1)) begin
                    cnt_s   = '0;
                    state_s = IDLE;
                end else begin
                    cnt_s   = cnt_r - CW'(1);
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // A new edge in the ack cycle wins over the clear of the same bit.
    assign pending_s = (pending & ~clr_s) | rise_s;

    // FSM, counter and registered request outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            irq_id      <= 4'd0;
            interrupter <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            irq_id      <= irq_id_s;
            interrupter <= int_s;
        end
    end

    // Pending latch and software mask register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            mask    <= '0;
        end else begin
            pending <= pending_s;
            if (mask_we) begin
                mask <= mask_wdata;
            end else begin
                mask <= mask;
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomised and directed bench for irq_ctrl with a timestamp-based reference model
// and a request scoreboard checked by an independent monitor.
module tb_irq_ctrl;

    localparam int N = 4;
    localparam int S = 2;
    localparam int H = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] src_in = '0;
    logic         mask_we = 1'b0;
    logic [N-1:0] mask_wdata = '0;
    logic         irq_ack = 1'b0;
    logic [N-1:0] mask;
    logic [N-1:0] pending;
    logic         interrupter;
    logic [3:0]   irq_id;

    irq_ctrl #(.N_SRC(N), .SYNC_STAGES(S), .HOLDOFF_CYC(H)) dut (
        .clk(clk), .rst(rst), .src_in(src_in), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .mask(mask), .interrupter(interrupter),
        .irq_id(irq_id), .irq_ack(irq_ack), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct { int id; int cyc; } req_t;
    req_t sb[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model state
    logic [N-1:0] hist[$];
    logic [N-1:0] exp_pend = '0;
    logic [N-1:0] exp_mask = '0;
    logic         exp_pres = 1'b0;
    int           exp_id   = 0;
    int           earliest = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < S + 2; i++) hist.push_back('0);
        exp_pend = '0;
        exp_mask = '0;
        exp_pres = 1'b0;
        exp_id   = 0;
        earliest = 0;
        sb.delete();
    endtask

    // Behaviour at edge number cyc, given the inputs held before it.
    task automatic model_edge(input logic [N-1:0] s, input logic we,
                              input logic [N-1:0] wd, input logic ack);
        logic [N-1:0] set_v, clr_v, elig;
        int w;
        hist.push_front(s);
        while (hist.size() > S + 2) void'(hist.pop_back());
        set_v = hist[S] & ~hist[S+1];
        clr_v = '0;
        elig  = exp_pend & exp_mask;
        if (exp_pres) begin
            if (ack) begin
                clr_v[exp_id] = 1'b1;
                exp_pres = 1'b0;
                earliest = cyc + H + 1;
            end
        end else if (cyc >= earliest && elig != '0) begin
            w = 0;
            for (int i = N - 1; i >= 0; i--) if (elig[i]) w = i;
            exp_pres = 1'b1;
            exp_id   = w;
            sb.push_back('{w, cyc});
        end
        exp_pend = (exp_pend & ~clr_v) | set_v;
        if (we) exp_mask = wd;
    endtask

    task automatic step(input logic [N-1:0] s, input logic we,
                        input logic [N-1:0] wd, input logic ack);
        src_in = s; mask_we = we; mask_wdata = wd; irq_ack = ack;
        @(posedge clk);
        cyc++;
        model_edge(s, we, wd, ack);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0, '0, 1'b0);
    endtask

    task automatic wait_req(input logic [N-1:0] s);
        for (int i = 0; i < 40 && !exp_pres; i++) step(s, 1'b0, '0, 1'b0);
        chk("req_wait", int'(interrupter), 1);
    endtask

    task automatic ack_req(input logic [N-1:0] s);
        wait_req(s);
        step(s, 1'b0, '0, 1'b1);
    endtask

    task automatic do_reset(input int n);
        logic was_req;
        was_req = exp_pres;
        rst = 1'b0;
        #1;
        if (was_req) chk("rst_async_int", int'(interrupter), 0);
        chk("rst_async_pend", int'(pending), 0);
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    // Monitor: compares outputs mid-cycle and pops the scoreboard on each new request.
    initial begin
        logic int_prev;
        req_t e;
        int_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("pending", int'(pending), int'(exp_pend));
                chk("mask", int'(mask), int'(exp_mask));
                chk("interrupter", int'(interrupter), int'(exp_pres));
                if (exp_pres) chk("irq_id_hold", int'(irq_id), exp_id);
                if (interrupter && !int_prev) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_req", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_id", int'(irq_id), e.id);
                        chk("sb_cycle", cyc, e.cyc);
                    end
                end
                int_prev = interrupter;
            end else begin
                int_prev = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] rs;
        model_reset();
        do_reset(3);

        // single source
        step('0, 1'b1, 4'b1111, 1'b0);
        step(4'b0100, 1'b0, '0, 1'b0);
        step(4'b0100, 1'b0, '0, 1'b0);
        ack_req('0);
        idle(6);

        // priority between simultaneous edges
        for (int i = 0; i < 3; i++) step(4'b1010, 1'b0, '0, 1'b0);
        ack_req('0);
        ack_req('0);
        idle(5);

        // masked source stays pending until unmasked
        step('0, 1'b1, 4'b0001, 1'b0);
        step(4'b0100, 1'b0, '0, 1'b0);
        step(4'b0100, 1'b0, '0, 1'b0);
        idle(6);
        step('0, 1'b1, 4'b0100, 1'b0);
        ack_req('0);
        idle(5);

        // new edge on source 0 lands in its ack cycle
        step('0, 1'b1, 4'b1111, 1'b0);
        idle(3);
        step(4'b0001, 1'b0, '0, 1'b0);
        step(4'b0001, 1'b0, '0, 1'b0);
        step('0, 1'b0, '0, 1'b0);
        step('0, 1'b0, '0, 1'b0);
        chk("collide_req", int'(interrupter), 1);
        step('0, 1'b0, '0, 1'b0);
        step(4'b0001, 1'b0, '0, 1'b0);
        step(4'b0001, 1'b0, '0, 1'b0);
        step(4'b0001, 1'b0, '0, 1'b1);
        chk("collide_pend0", int'(pending[0]), 1);
        ack_req(4'b0001);
        idle(5);

        // spurious ack, then reset while a request is presented
        step('0, 1'b0, '0, 1'b1);
        step('0, 1'b0, '0, 1'b1);
        step(4'b0100, 1'b0, '0, 1'b0);
        step(4'b0100, 1'b0, '0, 1'b0);
        wait_req('0);
        do_reset(3);
        idle(3);

        // level-high line triggers exactly once
        step('0, 1'b1, 4'b1111, 1'b0);
        for (int i = 0; i < 20; i++) step(4'b0010, 1'b0, '0, exp_pres);
        idle(6);

        // randomised traffic
        rs = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(5) == 0) rs[b] = ~rs[b];
            step(rs, ($urandom_range(15) == 0), 4'($urandom),
                 exp_pres ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0));
            if ($urandom_range(499) == 0) do_reset(2);
        end

        // drain: release lines, ack whatever is left
        for (int i = 0; i < 60; i++) step('0, 1'b0, '0, exp_pres);
        @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
